// File: rtl/dyt_rf_pkg.sv
// Shared register-file constants and the writeback arbiter priority state.
// Decode, the register file and the writeback path all import this package.
package dyt_rf_pkg;

    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WORDS  = 2 ** ADDR_WIDTH;

    typedef enum logic {
        PRI_LSU = 1'b0,
        PRI_ALU = 1'b1
    } arb_state_t;

    function automatic arb_state_t flip_pri(input arb_state_t s);
        return (s == PRI_LSU) ? PRI_ALU : PRI_LSU;
    endfunction

endpackage

// File: rtl/dyt_rr_arbiter2.sv
// Two-requester round-robin arbiter (ALU vs LSU) holding the priority flop.
// Grants are combinational from the requests and the current priority.
//
//   state   | meaning
//   PRI_LSU | on contention the LSU wins, then priority moves to the ALU
//   PRI_ALU | on contention the ALU wins, then priority moves to the LSU
module dyt_rr_arbiter2
    import dyt_rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req_alu,
    input  logic       i_req_lsu,
    output logic       o_gnt_alu,
    output logic       o_gnt_lsu,
    output arb_state_t o_state
);

    arb_state_t r_state;
    logic       w_both;

    assign w_both = i_req_alu & i_req_lsu;

    // Nothing is granted while reset is asserted, so no handshake can complete.
    always_comb begin
        o_gnt_lsu = ~rst & i_req_lsu & (~i_req_alu | (r_state == PRI_LSU));
        o_gnt_alu = ~rst & i_req_alu & (~i_req_lsu | (r_state == PRI_ALU));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PRI_LSU;
        end else if (w_both) begin
            r_state <= flip_pri(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/dyt_writeback_arbiter.sv
// Writeback arbiter: picks ALU or LSU result, registers it for one cycle and
// drives the register file write port; tracks outstanding destinations in busy_vec.
module dyt_writeback_arbiter
    import dyt_rf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    input  logic                  issue_en,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic [NUM_WORDS-1:0]  busy_vec,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data
);

    localparam logic [NUM_WORDS-1:0] ONE_HOT0 = {{(NUM_WORDS-1){1'b0}}, 1'b1};

    logic                  w_gnt_alu;
    logic                  w_gnt_lsu;
    arb_state_t            w_state;
    logic [ADDR_WIDTH-1:0] w_sel_rd;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_commit;
    logic [NUM_WORDS-1:0]  w_busy_set;
    logic [NUM_WORDS-1:0]  w_busy_clr;
    logic [NUM_WORDS-1:0]  w_busy_nxt;

    logic                  r_w_en;
    logic [ADDR_WIDTH-1:0] r_w_addr;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic [NUM_WORDS-1:0]  r_busy;

    dyt_rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req_alu (alu_valid),
        .i_req_lsu (lsu_valid),
        .o_gnt_alu (w_gnt_alu),
        .o_gnt_lsu (w_gnt_lsu),
        .o_state   (w_state)
    );

    assign alu_ready = w_gnt_alu;
    assign lsu_ready = w_gnt_lsu;

    always_comb begin
        w_sel_rd   = w_gnt_alu ? alu_rd   : lsu_rd;
        w_sel_data = w_gnt_alu ? alu_data : lsu_data;
        // x0 results complete the handshake but never reach the register file.
        w_commit   = (w_gnt_alu | w_gnt_lsu) && (w_sel_rd != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_en   <= 1'b0;
            r_w_addr <= '0;
            r_w_data <= '0;
        end else begin
            r_w_en <= w_commit;
            if (w_commit) begin
                r_w_addr <= w_sel_rd;
                r_w_data <= w_sel_data;
            end
        end
    end

    // A set in the same cycle as a clear means a newer writer is already in flight.
    always_comb begin
        w_busy_set = (issue_en && (issue_rd != '0)) ? (ONE_HOT0 << issue_rd) : '0;
        w_busy_clr = r_w_en ? (ONE_HOT0 << r_w_addr) : '0;
        w_busy_nxt = ((r_busy & ~w_busy_clr) | w_busy_set) & ~ONE_HOT0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;
    assign w_en     = r_w_en;
    assign w_addr   = r_w_addr;
    assign w_data   = r_w_data;

endmodule

// File: tb/tb_dyt_writeback_arbiter.sv
// Bench for dyt_writeback_arbiter: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the writeback rules.
module tb_dyt_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [3:0]  alu_rd, lsu_rd, issue_rd, w_addr;
    logic [31:0] alu_data, lsu_data, w_data;
    logic        issue_en, w_en;
    logic [15:0] busy_vec;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_pri_alu;
    bit          m_wen;
    logic [3:0]  m_waddr;
    logic [31:0] m_wdata;
    bit          m_busy [16];

    // Last observed values, for directed constant checks
    logic        obs_ar, obs_lr, obs_wen;
    logic [3:0]  obs_waddr;
    logic [31:0] obs_wdata;
    logic [15:0] obs_busy;

    always #5 clk = ~clk;

    dyt_writeback_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .issue_en  (issue_en),
        .issue_rd  (issue_rd),
        .busy_vec  (busy_vec),
        .w_en      (w_en),
        .w_addr    (w_addr),
        .w_data    (w_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_busy();
        logic [15:0] v;
        for (int i = 0; i < 16; i++) v[i] = m_busy[i];
        return v;
    endfunction

    task automatic model_reset();
        m_pri_alu = 1'b0;
        m_wen     = 1'b0;
        m_waddr   = 4'd0;
        m_wdata   = 32'd0;
        for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
    endtask

    task automatic cyc(input bit r,
                       input bit av, input logic [3:0] ard, input logic [31:0] ad,
                       input bit lv, input logic [3:0] lrd, input logic [31:0] ld,
                       input bit ie, input logic [3:0] ird);
        bit          ea, el;
        logic [3:0]  rd;
        logic [31:0] dt;
        @(negedge clk);
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        lsu_valid = lv; lsu_rd = lrd; lsu_data = ld; issue_en = ie; issue_rd = ird;
        #1;
        if (r) begin
            ea = 1'b0; el = 1'b0;
        end else if (av && lv) begin
            ea = m_pri_alu; el = !m_pri_alu;
        end else begin
            ea = av; el = lv;
        end
        obs_ar = alu_ready;
        obs_lr = lsu_ready;
        chk("alu_ready", 32'(alu_ready), 32'(ea));
        chk("lsu_ready", 32'(lsu_ready), 32'(el));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            for (int i = 0; i < 16; i++) begin
                bit set_hit, clr_hit;
                clr_hit   = m_wen && (m_waddr == 4'(i));
                set_hit   = ie && (ird == 4'(i)) && (i != 0);
                m_busy[i] = set_hit || (m_busy[i] && !clr_hit);
            end
            if (av && lv) m_pri_alu = !m_pri_alu;
            if (ea || el) begin
                rd    = ea ? ard : lrd;
                dt    = ea ? ad : ld;
                m_wen = (rd != 4'd0);
                if (rd != 4'd0) begin
                    m_waddr = rd;
                    m_wdata = dt;
                end
            end else begin
                m_wen = 1'b0;
            end
        end
        #1;
        obs_wen = w_en; obs_waddr = w_addr; obs_wdata = w_data; obs_busy = busy_vec;
        chk("w_en", 32'(w_en), 32'(m_wen));
        chk("w_addr", 32'(w_addr), 32'(m_waddr));
        chk("w_data", w_data, m_wdata);
        chk("busy_vec", 32'(busy_vec), 32'(model_busy()));
    endtask

    task automatic idle(input bit ie, input logic [3:0] ird);
        cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, ie, ird);
    endtask

    initial begin
        rst = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0; alu_rd = '0; lsu_rd = '0;
        alu_data = '0; lsu_data = '0; issue_en = 1'b0; issue_rd = '0;
        model_reset();

        // Reset held two cycles with both sources requesting
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b1, 4'd1, 32'hA, 1'b1, 4'd2, 32'hB, 1'b1, 4'd4);
            chk("t1_alu_ready", 32'(obs_ar), 32'd0);
            chk("t1_lsu_ready", 32'(obs_lr), 32'd0);
            chk("t1_w_en", 32'(obs_wen), 32'd0);
            chk("t1_busy", 32'(obs_busy), 32'h0000);
        end

        // Contention right after reset: LSU, ALU, LSU, ALU
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 4'd1, 32'hA000 + 32'(k), 1'b1, 4'd2, 32'hB000 + 32'(k), 1'b0, 4'd0);
            chk("t3_lsu_gnt", 32'(obs_lr), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3_w_addr", 32'(obs_waddr), (k % 2 == 0) ? 32'd2 : 32'd1);
        end

        // Single ALU source
        cyc(1'b0, 1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        chk("t2_alu_ready", 32'(obs_ar), 32'd1);
        chk("t2_w_en", 32'(obs_wen), 32'd1);
        chk("t2_w_addr", 32'(obs_waddr), 32'd3);
        chk("t2_w_data", obs_wdata, 32'hDEADBEEF);

        // Zero destination: accepted, never written, address/data held
        cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 32'h1, 1'b0, 4'd0);
        chk("t4_lsu_ready", 32'(obs_lr), 32'd1);
        chk("t4_w_en", 32'(obs_wen), 32'd0);
        chk("t4_w_addr_hold", 32'(obs_waddr), 32'd3);
        chk("t4_w_data_hold", obs_wdata, 32'hDEADBEEF);

        // Scoreboard set, clear two cycles after transfer, set-wins collision
        idle(1'b1, 4'd5);
        chk("t5_set", 32'(obs_busy[5]), 32'd1);
        cyc(1'b0, 1'b1, 4'd5, 32'h55, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        chk("t5_still_busy", 32'(obs_busy[5]), 32'd1);
        idle(1'b0, 4'd0);
        chk("t5_cleared", 32'(obs_busy[5]), 32'd0);
        cyc(1'b0, 1'b1, 4'd5, 32'h66, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        idle(1'b1, 4'd5);
        chk("t5_set_wins", 32'(obs_busy[5]), 32'd1);
        idle(1'b1, 4'd0);
        chk("t5_x0_never_busy", 32'(obs_busy[0]), 32'd0);

        // Reset while a committed result is in flight
        cyc(1'b0, 1'b1, 4'd7, 32'h77, 1'b1, 4'd8, 32'h88, 1'b1, 4'd9);
        cyc(1'b1, 1'b1, 4'd7, 32'h78, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        chk("t6_w_en", 32'(obs_wen), 32'd0);
        chk("t6_busy", 32'(obs_busy), 32'h0000);
        cyc(1'b0, 1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 1'b0, 4'd0);
        chk("t6_pri_lsu", 32'(obs_lr), 32'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)), $urandom,
                ($urandom_range(0, 9) < 3), 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
